// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hazard_pkg
// Description : Shared definitions for the ID-stage hazard scoreboard.
//               It holds the opcode constants, the 3-bit scoreboard counter
//               type, and the source-operand validity decode.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [3:0] OP_MOVR = 4'h1;
    localparam logic [3:0] OP_MOVI = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;

    // Countdown value held in each scoreboard entry.
    typedef logic [2:0] cnt3_t;

    // Reports whether a source field carries a real register read.
    // which = 0 selects src1 and which = 1 selects src2.
    function automatic logic src_valid(input logic [3:0] op,
                                       input logic       is_imm,
                                       input logic       st,
                                       input logic       which);
        logic v;
        if (!which)
            v = !((op == OP_MOVI) || (op == OP_BEQ) || (op == OP_JMP));
        else
            v = !(is_imm || st || (op == OP_MOVR) || (op == OP_BEQ) || (op == OP_JMP));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
// Module      : sb_entry
// Description : One scoreboard entry. It holds a pair of countdown counters:
//               one counts the cycles until the register-file write and one
//               counts the cycles until the result can be forwarded. A load
//               takes priority over the per-cycle saturating decrement.
// Revision    : 1.0 - initial release
// Ports       : clk        in  clock
//               rst        in  asynchronous active-high reset
//               load_i     in  reload both counters this cycle
//               wb_val_i   in  reload value for the write-back counter
//               fwd_val_i  in  reload value for the forwarding counter
//               wb_cnt_o   out current write-back countdown
//               fwd_cnt_o  out current forwarding countdown
// ============================================================================
module sb_entry
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  cnt3_t wb_val_i,
    input  cnt3_t fwd_val_i,
    output cnt3_t wb_cnt_o,
    output cnt3_t fwd_cnt_o
);

    cnt3_t wb_q, wb_d;
    cnt3_t fwd_q, fwd_d;

    always_comb begin
        wb_d  = (wb_q  != 3'd0) ? wb_q  - 3'd1 : 3'd0;
        fwd_d = (fwd_q != 3'd0) ? fwd_q - 3'd1 : 3'd0;
        if (load_i) begin
            wb_d  = wb_val_i;
            fwd_d = fwd_val_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q  <= 3'd0;
            fwd_q <= 3'd0;
        end else begin
            wb_q  <= wb_d;
            fwd_q <= fwd_d;
        end
    end

    assign wb_cnt_o  = wb_q;
    assign fwd_cnt_o = fwd_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Scoreboard-based ID-stage hazard check. It tracks the
//               in-flight writes for each register and stalls the ID
//               instruction while one of its valid sources is not yet
//               available, either by forwarding or from the register file.
//               It also keeps a saturating count of stalled cycles.
// Revision    : 1.0 - initial release
// Ports       : clk, rst                  clock and asynchronous high reset
//               id_valid, op              ID instruction qualifier and opcode
//               src1_id, src2_id, dest_id register fields
//               is_imm, st, wb_en         decode flags
//               mem_r_en                  ID instruction is a load
//               forward_en                forwarding network enabled
//               flush                     squash the ID instruction
//               hazard_detected           stall request (combinational)
//               pending_mask              registers with a write in flight
//               stall_cycles              saturating stall counter
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_REGS   = 16,
    parameter int OP_W       = 4,
    parameter int WB_LAT     = 3,
    parameter int ALU_FWD    = 0,
    parameter int LOAD_FWD   = 1,
    parameter int CNT_W      = 16,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [OP_W-1:0]       op,
    input  logic [REG_ADDR_W-1:0] src1_id,
    input  logic [REG_ADDR_W-1:0] src2_id,
    input  logic [REG_ADDR_W-1:0] dest_id,
    input  logic                  is_imm,
    input  logic                  st,
    input  logic                  wb_en,
    input  logic                  mem_r_en,
    input  logic                  forward_en,
    input  logic                  flush,
    output logic                  hazard_detected,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam cnt3_t C_WB_LAT   = cnt3_t'(WB_LAT);
    localparam cnt3_t C_ALU_FWD  = cnt3_t'(ALU_FWD);
    localparam cnt3_t C_LOAD_FWD = cnt3_t'(LOAD_FWD);

    cnt3_t            w_wb_cnt  [NUM_REGS];
    cnt3_t            w_fwd_cnt [NUM_REGS];
    cnt3_t            w_fwd_load;
    logic             w_src1_valid;
    logic             w_src2_valid;
    logic             w_use_fwd;
    logic             w_blk1;
    logic             w_blk2;
    logic             w_hazard;
    logic             w_issue;
    logic [CNT_W-1:0] stall_q, stall_d;

    // ---------------------------------------------------------------------
    // Source decode and compare mux
    // ---------------------------------------------------------------------
    assign w_src1_valid = src_valid(4'(op), is_imm, st, 1'b0)
                          && !((ZERO_REG != 0) && (src1_id == '0));
    assign w_src2_valid = src_valid(4'(op), is_imm, st, 1'b1)
                          && !((ZERO_REG != 0) && (src2_id == '0));

    // Branches resolve in ID and cannot use the forwarding path, so they
    // always wait for the register-file write.
    assign w_use_fwd = forward_en && (op != OP_W'(OP_BEQ));

    assign w_blk1 = w_src1_valid && (w_use_fwd ? (w_fwd_cnt[src1_id] != 3'd0)
                                               : (w_wb_cnt[src1_id]  != 3'd0));
    assign w_blk2 = w_src2_valid && (w_use_fwd ? (w_fwd_cnt[src2_id] != 3'd0)
                                               : (w_wb_cnt[src2_id]  != 3'd0));

    // The hazard is judged on the current state. This makes a self-dependent
    // instruction (src == dest) see the older write, not its own reload.
    assign w_hazard = id_valid && !flush && (w_blk1 || w_blk2);
    assign w_issue  = id_valid && !flush && !w_hazard && wb_en;

    assign w_fwd_load = mem_r_en ? C_LOAD_FWD : C_ALU_FWD;

    // ---------------------------------------------------------------------
    // Scoreboard entries
    // ---------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
            logic w_load;

            // A hardwired zero register is never written, so it is never tracked.
            assign w_load = w_issue && (dest_id == REG_ADDR_W'(i))
                            && !((ZERO_REG != 0) && (i == 0));

            sb_entry u_entry (
                .clk       (clk),
                .rst       (rst),
                .load_i    (w_load),
                .wb_val_i  (C_WB_LAT),
                .fwd_val_i (w_fwd_load),
                .wb_cnt_o  (w_wb_cnt[i]),
                .fwd_cnt_o (w_fwd_cnt[i])
            );

            assign pending_mask[i] = (w_wb_cnt[i] != 3'd0);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Saturating stall counter
    // ---------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (w_hazard && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign hazard_detected = w_hazard;
    assign stall_cycles    = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. The reference
//               model keeps, for each register, the absolute cycle at which
//               its value becomes forwardable and the cycle at which it
//               becomes visible in the register file. A second instance has
//               a 2-bit stall counter so that saturation is exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int WBL  = 3;
    localparam int ALUF = 0;
    localparam int LDF  = 1;

    localparam logic [3:0] ADD = 4'h5;
    localparam logic [3:0] SUB = 4'h6;
    localparam logic [3:0] LDR = 4'h7;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, is_imm, st, wb_en, mem_r_en, forward_en, flush;
    logic [3:0]  op, src1_id, src2_id, dest_id;
    logic        haz, haz2;
    logic [15:0] mask, mask2;
    logic [15:0] st1;
    logic [1:0]  st2;

    int checks = 0;
    int errors = 0;
    int now    = 0;
    int stalls = 0;
    int wb_ready  [16];
    int fwd_ready [16];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op(op),
        .src1_id(src1_id), .src2_id(src2_id), .dest_id(dest_id),
        .is_imm(is_imm), .st(st), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .forward_en(forward_en), .flush(flush),
        .hazard_detected(haz), .pending_mask(mask), .stall_cycles(st1)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .op(op),
        .src1_id(src1_id), .src2_id(src2_id), .dest_id(dest_id),
        .is_imm(is_imm), .st(st), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .forward_en(forward_en), .flush(flush),
        .hazard_detected(haz2), .pending_mask(mask2), .stall_cycles(st2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one cycle at posedge+1 and ends at the next posedge+1.
    task automatic step(input logic v, input logic [3:0] o,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                        input logic imm, input logic stv, input logic wb,
                        input logic mr, input logic fe, input logic fl);
        logic        v1, v2, uf, b1, b2, eh;
        logic [15:0] em;
        id_valid = v; op = o; src1_id = s1; src2_id = s2; dest_id = d;
        is_imm = imm; st = stv; wb_en = wb; mem_r_en = mr;
        forward_en = fe; flush = fl;
        #3;
        v1 = !(o == OP_MOVI || o == OP_BEQ || o == OP_JMP);
        v2 = !(imm || stv || o == OP_MOVR || o == OP_BEQ || o == OP_JMP);
        uf = fe && (o != OP_BEQ);
        b1 = v1 && (uf ? (now < fwd_ready[s1]) : (now < wb_ready[s1]));
        b2 = v2 && (uf ? (now < fwd_ready[s2]) : (now < wb_ready[s2]));
        eh = v && !fl && (b1 || b2);
        for (int r = 0; r < 16; r++) em[r] = (now < wb_ready[r]);
        check("hazard",     {31'd0, haz},  {31'd0, eh});
        check("hazard_sat", {31'd0, haz2}, {31'd0, eh});
        check("mask",       {16'd0, mask},  {16'd0, em});
        check("mask_sat",   {16'd0, mask2}, {16'd0, em});
        check("stall",      {16'd0, st1}, (stalls > 65535) ? 32'd65535 : 32'(stalls));
        check("stall_sat",  {30'd0, st2}, (stalls > 3) ? 32'd3 : 32'(stalls));
        @(posedge clk); #1;
        if (eh) stalls++;
        if (v && !fl && !eh && wb) begin
            wb_ready[d]  = now + 1 + WBL;
            fwd_ready[d] = now + 1 + (mr ? LDF : ALUF);
        end
        now++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; op = '0; src1_id = '0; src2_id = '0; dest_id = '0;
        is_imm = 1'b0; st = 1'b0; wb_en = 1'b0; mem_r_en = 1'b0;
        forward_en = 1'b0; flush = 1'b0;
        for (int r = 0; r < 16; r++) begin wb_ready[r] = 0; fwd_ready[r] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check("reset_hazard", {31'd0, haz}, 32'd0);
        check("reset_mask",   {16'd0, mask}, 32'd0);
        check("reset_stall",  {16'd0, st1}, 32'd0);
        rst = 1'b0;

        // ALU result forwarded back-to-back
        step(1, ADD, 4'd1, 4'd2, 4'd3, 0, 0, 1, 0, 1, 0);
        step(1, SUB, 4'd3, 4'd3, 4'd8, 0, 0, 1, 0, 1, 0);
        idle(4);

        // Load-use costs exactly one stall
        step(1, LDR, 4'd1, 4'd0, 4'd5, 1, 1, 1, 1, 1, 0);
        repeat (2) step(1, ADD, 4'd5, 4'd6, 4'd9, 0, 0, 1, 0, 1, 0);
        check("load_use_stalls", {16'd0, st1}, 32'd1);
        idle(4);

        // No forwarding: three stalls, issue on the fourth try
        step(1, ADD, 4'd1, 4'd3, 4'd2, 0, 0, 1, 0, 0, 0);
        repeat (4) step(1, SUB, 4'd2, 4'd1, 4'd10, 0, 0, 1, 0, 0, 0);
        check("nofwd_stalls", {16'd0, st1}, 32'd4);
        check("nofwd_sat",    {30'd0, st2}, 32'd3);
        idle(4);

        // Branch after ALU write with forwarding enabled
        step(1, ADD, 4'd1, 4'd2, 4'd4, 0, 0, 1, 0, 1, 0);
        repeat (4) step(1, OP_BEQ, 4'd4, 4'd4, 4'd0, 0, 0, 0, 0, 1, 0);
        idle(4);

        // Flushed consumer neither stalls nor issues
        step(1, ADD, 4'd1, 4'd3, 4'd2, 0, 0, 1, 0, 0, 0);
        step(1, SUB, 4'd2, 4'd2, 4'd11, 0, 0, 1, 0, 0, 1);
        idle(4);

        // Asynchronous reset in the middle of a stall
        step(1, ADD, 4'd1, 4'd3, 4'd2, 0, 0, 1, 0, 0, 0);
        step(1, SUB, 4'd2, 4'd1, 4'd12, 0, 0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_mask",   {16'd0, mask}, 32'd0);
        check("midrst_stall",  {16'd0, st1}, 32'd0);
        check("midrst_hazard", {31'd0, haz}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stalls = 0;
        for (int r = 0; r < 16; r++) begin wb_ready[r] = 0; fwd_ready[r] = 0; end
        idle(1);

        // Back-to-back writes to r7 reload the entry
        step(1, ADD, 4'd1, 4'd2, 4'd7, 0, 0, 1, 0, 1, 0);
        step(1, ADD, 4'd1, 4'd2, 4'd7, 0, 0, 1, 0, 1, 0);
        idle(4);

        // Randomised traffic on a small register window
        for (int n = 0; n < 400; n++) begin
            logic       rv, rimm, rst_v, rwb, rmr, rfe, rfl;
            logic [3:0] ro, rs1, rs2, rd;
            rv    = ($urandom_range(0, 9) != 0);
            ro    = 4'($urandom_range(0, 9));
            rs1   = 4'($urandom_range(0, 7));
            rs2   = 4'($urandom_range(0, 7));
            rd    = 4'($urandom_range(0, 7));
            rimm  = ($urandom_range(0, 3) == 0);
            rst_v = ($urandom_range(0, 4) == 0);
            rwb   = ($urandom_range(0, 3) != 0);
            rmr   = ($urandom_range(0, 2) == 0);
            rfe   = ($urandom_range(0, 3) != 0);
            rfl   = ($urandom_range(0, 15) == 0);
            step(rv, ro, rs1, rs2, rd, rimm, rst_v, rwb, rmr, rfe, rfl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
